// File: rtl/pipe_register_pkg.sv
// Core constants shared by the pipeline register and its stages.
package pipe_register_pkg;

  // Default pipeline depth for datapath-to-datapath hand-offs.
  localparam int PIPE_DEFAULT_STAGES = 2;

  // Total number of payload slots a pipeline can hold (main plus optional skid).
  function automatic int pipe_capacity(input int stages, input int skid);
    return stages * (1 + skid);
  endfunction

endpackage

// File: rtl/pipe_stage.sv
// One elastic pipeline stage: a main entry, plus an optional skid entry that
// lets the upstream ready be a register instead of a combinational chain.
module pipe_stage #(
  parameter int DATA_WIDTH = 64,
  parameter int SKID       = 0
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data
);

  logic                  valid_reg;
  logic [DATA_WIDTH-1:0] data_reg;

  assign out_valid = valid_reg;
  assign out_data  = data_reg;

  generate
    if (SKID == 0) begin : g_plain
      // An empty stage, or one whose entry leaves this cycle, can take a beat.
      assign in_ready = !valid_reg || out_ready;

      // Main entry: load on accept, clear when the entry leaves, drop all on flush.
      always_ff @(posedge clk) begin
        if (!rstn) begin
          valid_reg <= 1'b0;
          data_reg  <= '0;
        end else if (flush) begin
          valid_reg <= 1'b0;
        end else if (in_valid && in_ready) begin
          valid_reg <= 1'b1;
          data_reg  <= in_data;
        end else if (out_ready) begin
          valid_reg <= 1'b0;
        end
      end
    end else begin : g_skid
      logic                  skid_valid_reg;
      logic [DATA_WIDTH-1:0] skid_data_reg;
      logic                  in_fire;
      logic                  main_free;

      // Ready depends only on local state, so no ready path crosses the stage.
      assign in_ready  = !skid_valid_reg;
      assign in_fire   = in_valid && !skid_valid_reg;
      assign main_free = !valid_reg || out_ready;

      // Skid drains into main before any new beat, keeping beats in order.
      always_ff @(posedge clk) begin
        if (!rstn) begin
          valid_reg      <= 1'b0;
          data_reg       <= '0;
          skid_valid_reg <= 1'b0;
          skid_data_reg  <= '0;
        end else if (flush) begin
          valid_reg      <= 1'b0;
          skid_valid_reg <= 1'b0;
        end else if (main_free) begin
          if (skid_valid_reg) begin
            valid_reg      <= 1'b1;
            data_reg       <= skid_data_reg;
            skid_valid_reg <= 1'b0;
          end else if (in_fire) begin
            valid_reg <= 1'b1;
            data_reg  <= in_data;
          end else begin
            valid_reg <= 1'b0;
          end
        end else if (in_fire) begin
          skid_valid_reg <= 1'b1;
          skid_data_reg  <= in_data;
        end
      end
    end
  endgenerate

endmodule

// File: rtl/pipe_register.sv
// STAGES-deep elastic pipeline register with valid/ready handshake,
// synchronous flush and an occupancy count of held entries.
module pipe_register
  import pipe_register_pkg::*;
#(
  parameter  int DATA_WIDTH = 64,
  parameter  int STAGES     = PIPE_DEFAULT_STAGES,
  parameter  int SKID       = 0,
  localparam int CNT_W      = $clog2(pipe_capacity(STAGES, SKID) + 1)
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  i_flush,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic [CNT_W-1:0]      o_count
);

  // Handshake chain: index k is the input side of stage k, index STAGES the output.
  logic                  valid_chain [0:STAGES];
  logic                  ready_chain [0:STAGES];
  logic [DATA_WIDTH-1:0] data_chain  [0:STAGES];

  logic             in_acc;
  logic             out_acc;
  logic [CNT_W-1:0] count_reg;
  logic [CNT_W-1:0] count_next;

  assign valid_chain[0]      = i_valid;
  assign data_chain[0]       = i_data;
  assign ready_chain[STAGES] = i_ready;

  generate
    for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
      pipe_stage #(
        .DATA_WIDTH(DATA_WIDTH),
        .SKID      (SKID)
      ) u_stage (
        .clk      (clk),
        .rstn     (rstn),
        .flush    (i_flush),
        .in_valid (valid_chain[gi]),
        .in_ready (ready_chain[gi]),
        .in_data  (data_chain[gi]),
        .out_valid(valid_chain[gi+1]),
        .out_ready(ready_chain[gi+1]),
        .out_data (data_chain[gi+1])
      );
    end
  endgenerate

  // A flush cycle never accepts, so the dropped beat is not counted either.
  assign o_ready = ready_chain[0] && !i_flush;
  assign o_valid = valid_chain[STAGES];
  assign o_data  = data_chain[STAGES];
  assign o_count = count_reg;

  assign in_acc  = i_valid && o_ready;
  assign out_acc = o_valid && i_ready;

  // Occupancy update: flush empties, otherwise net of accept-in and accept-out.
  always_comb begin
    count_next = count_reg;
    if (i_flush) begin
      count_next = '0;
    end else if (in_acc && !out_acc) begin
      count_next = count_reg + CNT_W'(1);
    end else if (out_acc && !in_acc) begin
      count_next = count_reg - CNT_W'(1);
    end
  end

  // Occupancy register.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_next;
    end
  end

endmodule

// File: tb/tb_pipe_register.sv
// Directed and randomised checks for pipe_register, plain (a_*) and skid (b_*) variants.
module tb_pipe_register;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstn;
  logic        a_i_flush, a_i_valid, a_o_ready, a_o_valid, a_i_ready;
  logic [63:0] a_i_data, a_o_data;
  logic [1:0]  a_o_count;
  logic        b_i_flush, b_i_valid, b_o_ready, b_o_valid, b_i_ready;
  logic [63:0] b_i_data, b_o_data;
  logic [2:0]  b_o_count;

  int checks   = 0;
  int failures = 0;

  pipe_register #(.DATA_WIDTH(64), .STAGES(2), .SKID(0)) dut_a (
    .clk(clk), .rstn(rstn), .i_flush(a_i_flush), .i_valid(a_i_valid), .o_ready(a_o_ready),
    .i_data(a_i_data), .o_valid(a_o_valid), .i_ready(a_i_ready), .o_data(a_o_data),
    .o_count(a_o_count)
  );

  pipe_register #(.DATA_WIDTH(64), .STAGES(2), .SKID(1)) dut_b (
    .clk(clk), .rstn(rstn), .i_flush(b_i_flush), .i_valid(b_i_valid), .o_ready(b_o_ready),
    .i_data(b_i_data), .o_valid(b_o_valid), .i_ready(b_i_ready), .o_data(b_o_data),
    .o_count(b_o_count)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    a_i_flush = 0; a_i_valid = 0; a_i_data = '0; a_i_ready = 1;
    b_i_flush = 0; b_i_valid = 0; b_i_data = '0; b_i_ready = 1;
  endtask

  task automatic test_reset();
    rstn = 0;
    a_i_valid = 1; a_i_data = 64'hDEAD;
    b_i_valid = 1; b_i_data = 64'hDEAD;
    repeat (3) step();
    @(negedge clk);
    checks++; if (a_o_valid !== 1'b0) begin failures++; $display("FAIL reset_a_valid got=%b exp=0", a_o_valid); end
    checks++; if (a_o_data !== 64'h0) begin failures++; $display("FAIL reset_a_data got=%h exp=0", a_o_data); end
    checks++; if (a_o_count !== 2'd0) begin failures++; $display("FAIL reset_a_count got=%0d exp=0", a_o_count); end
    checks++; if (b_o_valid !== 1'b0) begin failures++; $display("FAIL reset_b_valid got=%b exp=0", b_o_valid); end
    checks++; if (b_o_data !== 64'h0) begin failures++; $display("FAIL reset_b_data got=%h exp=0", b_o_data); end
    checks++; if (b_o_count !== 3'd0) begin failures++; $display("FAIL reset_b_count got=%0d exp=0", b_o_count); end
    step();
    rstn = 1;
    a_i_valid = 0; b_i_valid = 0;
    repeat (3) step();
    @(negedge clk);
    checks++; if (a_o_valid !== 1'b0 || a_o_count !== 2'd0) begin failures++; $display("FAIL post_reset_a valid=%b count=%0d exp valid=0 count=0", a_o_valid, a_o_count); end
    checks++; if (b_o_valid !== 1'b0 || b_o_count !== 3'd0) begin failures++; $display("FAIL post_reset_b valid=%b count=%0d exp valid=0 count=0", b_o_valid, b_o_count); end
    step();
  endtask

  task automatic test_stream();
    int exp_cnt, ins, outs;
    bit exp_v;
    a_i_ready = 1; b_i_ready = 1;
    for (int c = 0; c < 12; c++) begin
      a_i_valid = (c < 8); a_i_data = 64'(c + 1);
      b_i_valid = (c < 8); b_i_data = 64'(c + 1);
      @(negedge clk);
      exp_v   = (c >= 2 && c < 10);
      ins     = (c < 8) ? c : 8;
      outs    = (c < 2) ? 0 : ((c < 10) ? c - 2 : 8);
      exp_cnt = ins - outs;
      checks++; if (a_o_ready !== 1'b1) begin failures++; $display("FAIL stream_a_ready c=%0d got=%b exp=1", c, a_o_ready); end
      checks++; if (a_o_valid !== exp_v) begin failures++; $display("FAIL stream_a_valid c=%0d got=%b exp=%b", c, a_o_valid, exp_v); end
      checks++; if (a_o_count !== 2'(exp_cnt)) begin failures++; $display("FAIL stream_a_count c=%0d got=%0d exp=%0d", c, a_o_count, exp_cnt); end
      checks++; if (b_o_valid !== exp_v) begin failures++; $display("FAIL stream_b_valid c=%0d got=%b exp=%b", c, b_o_valid, exp_v); end
      checks++; if (b_o_count !== 3'(exp_cnt)) begin failures++; $display("FAIL stream_b_count c=%0d got=%0d exp=%0d", c, b_o_count, exp_cnt); end
      if (exp_v) begin
        checks++; if (a_o_data !== 64'(c - 1)) begin failures++; $display("FAIL stream_a_data c=%0d got=%h exp=%h", c, a_o_data, 64'(c - 1)); end
        checks++; if (b_o_data !== 64'(c - 1)) begin failures++; $display("FAIL stream_b_data c=%0d got=%h exp=%h", c, b_o_data, 64'(c - 1)); end
      end
      step();
    end
    idle_inputs();
  endtask

  task automatic test_full();
    bit          tv [8] = '{1, 1, 1, 1, 1, 0, 0, 0};
    logic [63:0] td [8] = '{64'hA, 64'hB, 64'hC, 64'hC, 64'hC, 64'h0, 64'h0, 64'h0};
    bit          tr [8] = '{0, 0, 0, 0, 1, 1, 1, 1};
    bit          er [8] = '{1, 1, 0, 0, 1, 1, 1, 1};
    bit          ev [8] = '{0, 0, 1, 1, 1, 1, 1, 0};
    logic [63:0] ed [8] = '{64'h0, 64'h0, 64'hA, 64'hA, 64'hA, 64'hB, 64'hC, 64'h0};
    int          ec [8] = '{0, 1, 2, 2, 2, 2, 1, 0};
    for (int c = 0; c < 8; c++) begin
      a_i_valid = tv[c]; a_i_data = td[c]; a_i_ready = tr[c];
      @(negedge clk);
      checks++; if (a_o_ready !== er[c]) begin failures++; $display("FAIL full_ready c=%0d got=%b exp=%b", c, a_o_ready, er[c]); end
      checks++; if (a_o_valid !== ev[c]) begin failures++; $display("FAIL full_valid c=%0d got=%b exp=%b", c, a_o_valid, ev[c]); end
      checks++; if (a_o_count !== 2'(ec[c])) begin failures++; $display("FAIL full_count c=%0d got=%0d exp=%0d", c, a_o_count, ec[c]); end
      if (ev[c]) begin
        checks++; if (a_o_data !== ed[c]) begin failures++; $display("FAIL full_data c=%0d got=%h exp=%h", c, a_o_data, ed[c]); end
      end
      step();
    end
    idle_inputs();
  endtask

  task automatic test_skid();
    int idx = 0;
    b_i_ready = 0;
    for (int c = 0; c < 6; c++) begin
      b_i_valid = (idx < 5); b_i_data = 64'(idx + 1);
      @(negedge clk);
      checks++; if (b_o_ready !== (c < 4)) begin failures++; $display("FAIL skid_ready c=%0d got=%b exp=%b", c, b_o_ready, (c < 4)); end
      if (b_i_valid && b_o_ready) idx++;
      step();
    end
    b_i_valid = 0;
    @(negedge clk);
    checks++; if (b_o_count !== 3'd4) begin failures++; $display("FAIL skid_count got=%0d exp=4", b_o_count); end
    checks++; if (idx != 4) begin failures++; $display("FAIL skid_accepted got=%0d exp=4", idx); end
    checks++; if (b_o_ready !== 1'b0) begin failures++; $display("FAIL skid_full_ready got=%b exp=0", b_o_ready); end
    step();
    b_i_ready = 1;
    for (int r = 0; r < 5; r++) begin
      @(negedge clk);
      checks++; if (b_o_valid !== (r < 4)) begin failures++; $display("FAIL skid_drain_valid r=%0d got=%b exp=%b", r, b_o_valid, (r < 4)); end
      checks++; if (b_o_count !== 3'(4 - r)) begin failures++; $display("FAIL skid_drain_count r=%0d got=%0d exp=%0d", r, b_o_count, 4 - r); end
      if (r < 4) begin
        checks++; if (b_o_data !== 64'(r + 1)) begin failures++; $display("FAIL skid_drain_data r=%0d got=%h exp=%h", r, b_o_data, 64'(r + 1)); end
      end
      step();
    end
    idle_inputs();
  endtask

  task automatic test_flush();
    a_i_ready = 0;
    a_i_valid = 1; a_i_data = 64'h11;
    step();
    a_i_data = 64'h22;
    step();
    a_i_flush = 1; a_i_data = 64'h55;
    @(negedge clk);
    checks++; if (a_o_ready !== 1'b0) begin failures++; $display("FAIL flush_ready got=%b exp=0", a_o_ready); end
    checks++; if (a_o_count !== 2'd2) begin failures++; $display("FAIL flush_held_count got=%0d exp=2", a_o_count); end
    step();
    a_i_flush = 0; a_i_valid = 0;
    @(negedge clk);
    checks++; if (a_o_valid !== 1'b0) begin failures++; $display("FAIL flush_valid got=%b exp=0", a_o_valid); end
    checks++; if (a_o_count !== 2'd0) begin failures++; $display("FAIL flush_count got=%0d exp=0", a_o_count); end
    checks++; if (a_o_ready !== 1'b1) begin failures++; $display("FAIL flush_after_ready got=%b exp=1", a_o_ready); end
    step();
    a_i_ready = 1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      checks++; if (a_o_valid !== 1'b0) begin failures++; $display("FAIL flush_leak c=%0d valid=%b data=%h exp valid=0", c, a_o_valid, a_o_data); end
      step();
    end
    idle_inputs();
  endtask

  task automatic test_random(input int n);
    logic [63:0] qa[$];
    logic [63:0] qb[$];
    bit pa = 0, pb = 0, exp_ra;
    for (int c = 0; c < n; c++) begin
      checks++; if (a_o_count !== 2'(qa.size())) begin failures++; $display("FAIL rand_a_count c=%0d got=%0d exp=%0d", c, a_o_count, qa.size()); end
      checks++; if (b_o_count !== 3'(qb.size())) begin failures++; $display("FAIL rand_b_count c=%0d got=%0d exp=%0d", c, b_o_count, qb.size()); end
      a_i_flush = ($urandom_range(0, 31) == 0);
      b_i_flush = ($urandom_range(0, 31) == 0);
      if (!pa) begin a_i_valid = ($urandom_range(0, 9) < 7); a_i_data = {$urandom, $urandom}; end
      if (!pb) begin b_i_valid = ($urandom_range(0, 9) < 7); b_i_data = {$urandom, $urandom}; end
      a_i_ready = ($urandom_range(0, 9) < 6);
      b_i_ready = ($urandom_range(0, 9) < 6);
      @(negedge clk);
      exp_ra = !a_i_flush && (qa.size() < 2 || a_i_ready);
      checks++; if (a_o_ready !== exp_ra) begin failures++; $display("FAIL rand_a_ready c=%0d got=%b exp=%b", c, a_o_ready, exp_ra); end
      if (a_o_valid) begin
        checks++; if (qa.size() == 0 || a_o_data !== qa[0]) begin failures++; $display("FAIL rand_a_data c=%0d got=%h exp=%h", c, a_o_data, (qa.size() == 0) ? 64'hX : qa[0]); end
      end
      if (b_i_flush || qb.size() == 4) begin
        checks++; if (b_o_ready !== 1'b0) begin failures++; $display("FAIL rand_b_ready c=%0d got=%b exp=0", c, b_o_ready); end
      end
      if (b_o_valid) begin
        checks++; if (qb.size() == 0 || b_o_data !== qb[0]) begin failures++; $display("FAIL rand_b_data c=%0d got=%h exp=%h", c, b_o_data, (qb.size() == 0) ? 64'hX : qb[0]); end
      end
      if (a_o_valid && a_i_ready && qa.size() > 0) void'(qa.pop_front());
      if (a_i_flush) qa.delete(); else if (a_i_valid && a_o_ready) qa.push_back(a_i_data);
      pa = a_i_valid && !a_o_ready && !a_i_flush;
      if (b_o_valid && b_i_ready && qb.size() > 0) void'(qb.pop_front());
      if (b_i_flush) qb.delete(); else if (b_i_valid && b_o_ready) qb.push_back(b_i_data);
      pb = b_i_valid && !b_o_ready && !b_i_flush;
      step();
    end
    idle_inputs();
    repeat (10) step();
    @(negedge clk);
    checks++; if (a_o_valid !== 1'b0 || a_o_count !== 2'd0) begin failures++; $display("FAIL rand_a_drain valid=%b count=%0d exp valid=0 count=0", a_o_valid, a_o_count); end
    checks++; if (b_o_valid !== 1'b0 || b_o_count !== 3'd0) begin failures++; $display("FAIL rand_b_drain valid=%b count=%0d exp valid=0 count=0", b_o_valid, b_o_count); end
    step();
  endtask

  initial begin
    rstn = 0;
    idle_inputs();
    test_reset();
    test_stream();
    test_full();
    test_skid();
    test_flush();
    test_random(10000);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipe_register.md
Name: pipe_register

Overview:
- Parametrised successor to the plain nonarchitectural register: a STAGES-deep elastic pipeline register carrying DATA_WIDTH-bit payloads with a valid/ready handshake, synchronous flush and occupancy count.
- Used between datapath units (fetch→decode, memory response paths) where a fixed one-cycle, unconditional register is not enough because back-pressure and squash must be honoured.
- Optional skid mode registers the ready path to break long combinational ready chains.

Parameters:
- DATA_WIDTH, 64, payload width in bits (≥1).
- STAGES, 2, number of pipeline stages (≥1); latency with no back-pressure.
- SKID, 0, 0 = combinational ready chain; 1 = each stage has a skid entry and a registered ready.
- CNT_W, $clog2(STAGES*(1+SKID)+1), occupancy counter width (derived, not overridden).

Ports:
- clk  input  1  clock, all state on rising edge.
- rstn  input  1  synchronous reset, active-low.
- i_flush  input  1  squash all held entries.
- i_valid  input  1  upstream payload valid.
- o_ready  output  1  pipeline can accept this cycle.
- i_data  input  DATA_WIDTH  upstream payload.
- o_valid  output  1  head entry valid.
- i_ready  input  1  downstream accepts head entry.
- o_data  output  DATA_WIDTH  head payload.
- o_count  output  CNT_W  number of valid entries held.

Behaviour:
- Reset (rstn=0 at clk edge): all valid bits, skid valid bits and o_count → 0; all data registers → 0. o_valid=0, o_data=0 from the first post-reset cycle. Reset overrides flush and handshakes.
- Transfer rule: a beat moves across an interface only when valid && ready are both high at a rising edge. Upstream must hold i_data stable while i_valid && !o_ready; the block holds o_data stable while o_valid && !i_ready.
- SKID=0: stage k ready = !valid[k] || ready[k+1]; last stage uses i_ready. o_ready = stage 0 ready (combinational through all stages). Latency from input accept to o_valid = STAGES cycles; throughput 1 beat/cycle with i_ready held high.
- SKID=1: each stage holds main + skid entry. o_ready_k = !skid_valid[k] (registered). When the main entry is stalled and a beat arrives, it lands in skid; skid drains into main first when downstream accepts, so ordering is preserved. Latency unchanged (STAGES); full throughput preserved; capacity 2*STAGES.
- Bubble collapse: an empty stage always accepts, even when a downstream stage is stalled.
- Full: o_ready=0 only when every entry is valid and i_ready=0 (SKID=0), or stage 0 skid is full (SKID=1). Extra i_valid is not captured.
- Empty: o_valid=0, o_count=0; o_data holds its last value (don't-care for consumers).
- Flush (i_flush=1 at edge): every valid/skid-valid bit → 0, o_count → 0 next cycle; any beat presented that cycle is dropped; o_ready forced 0 during the flush cycle; a head beat accepted downstream in the same cycle is counted as delivered.
- o_count: +1 on input accept, −1 on output accept, unchanged on simultaneous accept; never wraps (saturates by construction at STAGES*(1+SKID)).
- Simultaneous full + i_ready=1 (SKID=0): o_ready=1; head leaves and new beat enters same edge, count unchanged.

Decomposition:
- Shared package: no new typedefs needed; add a constant PIPE_DEFAULT_STAGES = 2 to the existing core constants package.
- Natural sub-module: pipe_stage (one stage; DATA_WIDTH, SKID parameters; valid/ready/data in and out, flush, reset). pipe_register is a generate loop of STAGES instances plus the occupancy counter.

Test Plan:
- Reset: drive rstn=0 with i_valid=1, i_data=64'hDEAD for 3 cycles → o_valid=0, o_data=0, o_count=0, nothing captured after release.
- Streaming: STAGES=2, SKID=0, i_ready=1, send 0x1..0x8 back-to-back → o_valid rises 2 cycles after first accept; 0x1..0x8 emerge in order, one per cycle; o_count steady at 2.
- Back-pressure/full: i_ready=0, send 0xA,0xB,0xC → 0xA,0xB captured, o_ready=0 with 0xC held, o_count=2; raise i_ready → 0xA,0xB,0xC delivered, no loss/duplication.
- Skid: SKID=1, STAGES=2, i_ready=0, offer 5 beats → exactly 4 accepted, o_ready registered low, o_count=4; release → all 4 in order at 1/cycle.
- Flush: 2 entries held, assert i_flush with i_valid=1, i_data=0x55 → next cycle o_valid=0, o_count=0, 0x55 never emerges.
- Random: random i_valid/i_ready/i_flush 10k cycles vs scoreboard queue → ordering, count and handshake-stability assertions hold.
